// File: rtl/trace_stream_encoder.sv
// trace_stream_encoder: buffers retire records in a FIFO and serialises each into a 4-7 word trace packet
module trace_stream_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_tick,
    input  logic        i_ok,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic [4:0]  i_regWrAddr,
    input  logic        i_regWrEnable,
    input  logic [31:0] i_regWrData,
    input  logic [31:0] i_memWrAddr,
    input  logic        i_memWrEnable,
    input  logic [31:0] i_memWrData,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_last,
    input  logic        i_ready,
    output logic [15:0] o_dropCount,
    output logic        o_busy
);
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        logic [31:0] tick, pc, inst, reg_data, mem_addr, mem_data;
        logic [4:0]  rd;
        logic        rv, mv, lost;
    } rec_t;
    typedef enum logic [2:0] {IDLE, HDR, TICK, PC, INST, REG, MADDR, MDATA} state_t;
    state_t state;
    rec_t mem [DEPTH];
    rec_t head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic lost_flag, push, drop, pop, rv;
    assign rv = i_regWrEnable & (i_regWrAddr != 5'd0);
    assign head = mem[rd_ptr];
    // count never exceeds DEPTH, so its top bit alone means full
    assign push = i_ok & !count[AW];
    assign drop = i_ok & count[AW];
    assign o_valid = state != IDLE;
    assign o_last = (state == MDATA) | ((state == REG) & !head.mv) | ((state == INST) & !head.rv & !head.mv);
    assign pop = o_valid & i_ready & o_last;
    assign o_busy = (|count) | o_valid;
    always_comb
        o_data = state == HDR   ? {8'hA5, head.rv, head.mv, head.lost, head.rd, 16'h0} :
                 state == TICK  ? head.tick :
                 state == PC    ? head.pc :
                 state == INST  ? head.inst :
                 state == REG   ? head.reg_data :
                 state == MADDR ? head.mem_addr :
                 state == MDATA ? head.mem_data : 32'h0;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            lost_flag   <= 1'b0;
            o_dropCount <= 16'h0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{tick: i_tick, pc: i_pc, inst: i_inst, reg_data: i_regWrData,
                                 mem_addr: i_memWrAddr, mem_data: i_memWrData,
                                 rd: rv ? i_regWrAddr : 5'd0, rv: rv, mv: i_memWrEnable, lost: lost_flag};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            lost_flag <= drop | (lost_flag & !push);
            if (drop & ~&o_dropCount)
                o_dropCount <= o_dropCount + 16'd1;
            if (state == IDLE)
                state <= |count ? HDR : IDLE;
            else if (i_ready)
                state <= state == INST  ? (head.rv ? REG : head.mv ? MADDR : IDLE) :
                         state == REG   ? (head.mv ? MADDR : IDLE) :
                         state == MDATA ? IDLE : state_t'(state + 3'd1);
        end
    end
endmodule

// File: tb/tb_trace_stream_encoder.sv
// tb_trace_stream_encoder: random and directed retire records checked through a packet scoreboard
module tb_trace_stream_encoder;
    localparam int DEPTH = 4;
    logic        i_clock = 1'b0, i_reset = 1'b1, i_ok = 1'b0, i_ready = 1'b1;
    logic [31:0] i_tick = '0, i_pc = '0, i_inst = '0, i_regWrData = '0, i_memWrAddr = '0, i_memWrData = '0;
    logic [4:0]  i_regWrAddr = '0;
    logic        i_regWrEnable = 1'b0, i_memWrEnable = 1'b0;
    logic        o_valid, o_last, o_busy;
    logic [31:0] o_data;
    logic [15:0] o_dropCount;

    trace_stream_encoder #(.DEPTH(DEPTH)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_ok(i_ok), .i_pc(i_pc), .i_inst(i_inst),
        .i_regWrAddr(i_regWrAddr), .i_regWrEnable(i_regWrEnable), .i_regWrData(i_regWrData),
        .i_memWrAddr(i_memWrAddr), .i_memWrEnable(i_memWrEnable), .i_memWrData(i_memWrData),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready),
        .o_dropCount(o_dropCount), .o_busy(o_busy)
    );

    always #5 i_clock = ~i_clock;

    int checks = 0, errors = 0;
    logic [32:0] exp_q[$];
    int occ = 0, exp_drop = 0;
    bit lost = 0;
    int ready_mode = 0;
    logic manual_ready = 1'b1;
    logic [31:0] tick_ctr = 32'd1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: decides push/drop for the coming edge from record occupancy and builds packets
    always @(negedge i_clock) begin
        logic [32:0] w[$];
        bit r, popping;
        check("drop_count", 64'(o_dropCount), 64'(exp_drop));
        check("busy", 64'(o_busy), 64'(occ != 0));
        if (i_reset) begin
            exp_q.delete();
            occ = 0;
            exp_drop = 0;
            lost = 0;
        end else begin
            popping = o_valid && i_ready && o_last;
            if (i_ok) begin
                if (occ < DEPTH) begin
                    r = i_regWrEnable && i_regWrAddr != 0;
                    w = {};
                    w.push_back({1'b0, 8'hA5, r, i_memWrEnable, lost, r ? i_regWrAddr : 5'd0, 16'h0});
                    w.push_back({1'b0, i_tick});
                    w.push_back({1'b0, i_pc});
                    w.push_back({1'b0, i_inst});
                    if (r) w.push_back({1'b0, i_regWrData});
                    if (i_memWrEnable) begin
                        w.push_back({1'b0, i_memWrAddr});
                        w.push_back({1'b0, i_memWrData});
                    end
                    w[w.size()-1][32] = 1'b1;
                    foreach (w[k]) exp_q.push_back(w[k]);
                    lost = 0;
                    occ++;
                end else begin
                    if (exp_drop < 65535) exp_drop++;
                    lost = 1;
                end
            end
            if (popping) occ--;
        end
    end

    // Monitor: compares each accepted word with the scoreboard and checks stall stability
    logic stalled = 1'b0;
    logic [32:0] held = '0;
    always @(negedge i_clock) begin
        if (stalled) check("hold", 64'({o_valid, o_last, o_data}), 64'({1'b1, held}));
        if (!o_valid) check("idle_data", 64'(o_data), 64'(0));
        stalled = !i_reset && o_valid && !i_ready;
        held = {o_last, o_data};
        if (!i_reset && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word: unexpected word %h last %b with empty scoreboard", o_data, o_last);
            end else
                check("word", 64'({o_last, o_data}), 64'(exp_q.pop_front()));
        end
    end

    task automatic cyc();
        @(posedge i_clock);
        #1;
        i_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~i_ready :
                  ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 3 ? 1'b0 : manual_ready;
    endtask

    task automatic send(input logic [31:0] pc, inst, input logic [4:0] rd, input logic we,
                        input logic [31:0] rdata, input logic me, input logic [31:0] ma, md);
        i_ok = 1'b1; i_tick = tick_ctr; tick_ctr++;
        i_pc = pc; i_inst = inst; i_regWrAddr = rd; i_regWrEnable = we; i_regWrData = rdata;
        i_memWrEnable = me; i_memWrAddr = ma; i_memWrData = md;
        cyc();
        i_ok = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 1000) begin
            cyc();
            n++;
        end
        check("drain_timeout", 64'(n < 1000), 64'(1));
    endtask

    initial begin
        cyc(); cyc();
        i_reset = 1'b0;
        cyc();
        send(32'h100, 32'h00500093, 5'd1, 1'b1, 32'd5, 1'b0, 32'h0, 32'h0);
        drain();
        send(32'h104, 32'h00000013, 5'd0, 1'b1, 32'h77, 1'b0, 32'h0, 32'h0);
        send(32'h108, 32'h00000013, 5'd3, 1'b0, 32'h55, 1'b0, 32'h0, 32'h0);
        drain();
        send(32'h10C, 32'h00112023, 5'd0, 1'b0, 32'h0, 1'b1, 32'h2000, 32'hDEADBEEF);
        send(32'h110, 32'h00112023, 5'd7, 1'b1, 32'h1234, 1'b1, 32'h3000, 32'hCAFEF00D);
        drain();
        ready_mode = 1;
        send(32'h100, 32'h00500093, 5'd1, 1'b1, 32'd5, 1'b0, 32'h0, 32'h0);
        send(32'h10C, 32'h00112023, 5'd0, 1'b0, 32'h0, 1'b1, 32'h2000, 32'hDEADBEEF);
        drain();
        ready_mode = 3;
        cyc();
        for (int i = 0; i < DEPTH + 3; i++)
            send(32'h200 + 32'(4 * i), 32'h13, 5'(i + 1), 1'b1, 32'(i), 1'b0, 32'h0, 32'h0);
        @(negedge i_clock);
        check("overflow_drops", 64'(o_dropCount), 64'(3));
        ready_mode = 0;
        cyc();
        drain();
        send(32'h300, 32'h13, 5'd2, 1'b1, 32'h99, 1'b0, 32'h0, 32'h0);
        send(32'h304, 32'h13, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        drain();
        ready_mode = 4;
        manual_ready = 1'b0;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'h400 + 32'(4 * i), 32'h13, 5'd4, 1'b1, 32'(i), 1'b1, 32'h4000, 32'(i));
        manual_ready = 1'b1;
        i_ready = 1'b1;
        cyc(); cyc();
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        @(negedge i_clock);
        check("reset_valid", 64'(o_valid), 64'(0));
        check("reset_busy", 64'(o_busy), 64'(0));
        check("reset_drops", 64'(o_dropCount), 64'(0));
        ready_mode = 0;
        cyc();
        send(32'h500, 32'h00500093, 5'd1, 1'b1, 32'd5, 1'b0, 32'h0, 32'h0);
        drain();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) ready_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 9) < 4)
                send($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                     1'($urandom), $urandom, 1'($urandom), $urandom, $urandom);
            else
                cyc();
        end
        ready_mode = 0;
        drain();
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
